// File: rtl/video_timing_gen_if.sv
// Raster output bundle of video_timing_gen: sync, visible-pixel flag, coordinates,
// frame bookkeeping, the early fetch position and the test-pattern colour.
interface video_timing_gen_if;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [11:0] x;
   logic [11:0] y;
   logic        line_start;
   logic        frame_start;
   logic [15:0] frame_count;
   logic        fetch_valid;
   logic [11:0] fetch_x;
   logic [11:0] fetch_y;
   logic [23:0] rgb;

   modport master (
      output hsync, vsync, de, x, y, line_start, frame_start, frame_count,
             fetch_valid, fetch_x, fetch_y, rgb
   );

   modport slave (
      input  hsync, vsync, de, x, y, line_start, frame_start, frame_count,
             fetch_valid, fetch_x, fetch_y, rgb
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, registered sync/de/coordinate decode,
// a fetch position running PREFETCH cycles ahead, and a built-in test-pattern source.
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PREFETCH = 2
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic [1:0]                 pattern_sel,
   video_timing_gen_if.master         vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   generate
      if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_size_check
         $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 4095");
      end
      if (PREFETCH < 0 || PREFETCH > H_FRONT + H_SYNC + H_BACK) begin : g_prefetch_check
         $error("video_timing_gen: PREFETCH must lie within the horizontal blanking");
      end
   endgenerate

   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] H_TOT    = 12'(H_TOTAL);
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FRONT);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [11:0] PF       = 12'(PREFETCH);
   localparam logic [11:0] BAR_W    = 12'(H_ACTIVE / 8);

   logic [11:0] h;
   logic [11:0] v;
   logic [1:0]  pat_q;

   // Idle position is the start of vertical front porch, so the first frame gets its fetch lead.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h <= '0;
         v <= V_ACT;
      end else if (!enable) begin
         h <= '0;
         v <= V_ACT;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? 12'd0 : v + 12'd1;
      end else begin
         h <= h + 12'd1;
      end
   end

   logic [11:0] src_h;
   logic [11:0] src_v;
   logic [12:0] fh_sum;
   logic [11:0] fh;
   logic [11:0] fv;
   logic        de_n;
   logic        line_start_n;
   logic        frame_start_n;
   logic        fetch_valid_n;
   logic        hsync_n;
   logic        vsync_n;
   logic [1:0]  pat_eff;
   logic [2:0]  bar;
   logic [11:0] bar_wide;
   logic [23:0] rgb_n;

   always_comb begin
      src_h         = enable ? h : 12'd0;
      src_v         = enable ? v : V_ACT;
      fh_sum        = {1'b0, src_h} + {1'b0, PF};
      fh            = fh_sum[11:0];
      fv            = src_v;
      if (fh_sum >= {1'b0, H_TOT}) begin
         fh = 12'(fh_sum - {1'b0, H_TOT});
         fv = (src_v == V_LAST) ? 12'd0 : src_v + 12'd1;
      end

      de_n          = enable && (h < H_ACT) && (v < V_ACT);
      line_start_n  = enable && (h == 12'd0);
      frame_start_n = enable && (h == 12'd0) && (v == 12'd0);
      fetch_valid_n = enable && (fh < H_ACT) && (fv < V_ACT);
      hsync_n       = ((src_h >= HS_START) && (src_h < HS_END)) ? HS_POL : ~HS_POL;
      vsync_n       = ((src_v >= VS_START) && (src_v < VS_END)) ? VS_POL : ~VS_POL;

      // The first pixel of a frame already uses the newly selected pattern.
      pat_eff       = frame_start_n ? pattern_sel : pat_q;
      bar_wide      = h / BAR_W;
      bar           = bar_wide[2:0];
      rgb_n         = 24'h000000;
      if (de_n) begin
         case (pat_eff)
            2'd1: begin
               case (bar)
                  3'd0:    rgb_n = 24'hFFFFFF;
                  3'd1:    rgb_n = 24'hFFFF00;
                  3'd2:    rgb_n = 24'h00FFFF;
                  3'd3:    rgb_n = 24'h00FF00;
                  3'd4:    rgb_n = 24'hFF00FF;
                  3'd5:    rgb_n = 24'hFF0000;
                  3'd6:    rgb_n = 24'h0000FF;
                  default: rgb_n = 24'h000000;
               endcase
            end
            2'd2:    rgb_n = (h[5] ^ v[5]) ? 24'hFFFFFF : 24'h000000;
            2'd3:    rgb_n = {h[7:0], v[7:0], h[7:0] ^ v[7:0]};
            default: rgb_n = 24'h000000;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vid.hsync       <= ~HS_POL;
         vid.vsync       <= ~VS_POL;
         vid.de          <= 1'b0;
         vid.x           <= '0;
         vid.y           <= V_ACT;
         vid.line_start  <= 1'b0;
         vid.frame_start <= 1'b0;
         vid.frame_count <= '0;
         vid.fetch_valid <= 1'b0;
         vid.fetch_x     <= PF;
         vid.fetch_y     <= V_ACT;
         vid.rgb         <= '0;
         pat_q           <= '0;
      end else begin
         vid.hsync       <= hsync_n;
         vid.vsync       <= vsync_n;
         vid.de          <= de_n;
         vid.x           <= src_h;
         vid.y           <= src_v;
         vid.line_start  <= line_start_n;
         vid.frame_start <= frame_start_n;
         vid.fetch_valid <= fetch_valid_n;
         vid.fetch_x     <= fh;
         vid.fetch_y     <= fv;
         vid.rgb         <= rgb_n;
         if (frame_start_n) begin
            vid.frame_count <= vid.frame_count + 16'd1;
            pat_q           <= pattern_sel;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster: a step-count model feeds a scoreboard
// every cycle, alongside directed checks of latency, frame counts, patterns and resets.
module tb_video_timing_gen;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 16, VF = 2, VS = 2, VB = 3;
   localparam int PF = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int LEAD = (VT - VA) * HT + 1;

   typedef struct packed {
      logic [5:0]  flags;
      logic [23:0] xy;
      logic [23:0] fxy;
      logic [23:0] rgb;
      logic [15:0] fc;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] pattern_sel = 2'd0;

   int checkCount = 0;
   int errorCount = 0;

   exp_t expQ[$];
   logic [23:0] barColour [8];

   video_timing_gen_if vid();

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(PF)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .enable(enable),
      .pattern_sel(pattern_sel),
      .vid(vid)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [1:0] pat);
      enable      = en;
      pattern_sel = pat;
   endtask

   function automatic logic [23:0] modelRgb(input logic [1:0] pat, input int px, input int py);
      int r, g, b;
      case (pat)
         2'd1:    return barColour[px / (HA / 8)];
         2'd2:    return ((((px >> 5) ^ (py >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
         2'd3: begin
            r = px & 255;
            g = py & 255;
            b = (px ^ py) & 255;
            return {8'(r), 8'(g), 8'(b)};
         end
         default: return 24'h000000;
      endcase
   endfunction

   // Reference model: position is derived from the number of enabled steps since idle.
   int          mStep = 0;
   logic [15:0] mFrames = '0;
   logic [1:0]  mPat = '0;
   initial begin
      barColour = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) begin
            mStep   = 0;
            mFrames = '0;
            mPat    = '0;
            expQ.delete();
         end else begin
            int h, v, q, fh, fv;
            bit de, hsAct, vsAct, ls, fs, fvld;
            exp_t e;
            if (enable) begin
               h     = mStep % HT;
               v     = (VA + mStep / HT) % VT;
               q     = mStep + PF;
               fh    = q % HT;
               fv    = (VA + q / HT) % VT;
               fs    = (h == 0) && (v == 0);
               if (fs) begin
                  mPat    = pattern_sel;
                  mFrames = mFrames + 16'd1;
               end
               de    = (h < HA) && (v < VA);
               ls    = (h == 0);
               fvld  = (fh < HA) && (fv < VA);
               hsAct = (h >= HA + HF) && (h < HA + HF + HS);
               vsAct = (v >= VA + VF) && (v < VA + VF + VS);
               e.rgb = de ? modelRgb(mPat, h, v) : 24'h0;
               mStep = (mStep + 1) % FRAME;
            end else begin
               h = 0; v = VA; fh = PF; fv = VA;
               de = 0; ls = 0; fs = 0; fvld = 0; hsAct = 0; vsAct = 0;
               e.rgb = 24'h0;
               mStep = 0;
            end
            e.flags = {~hsAct, ~vsAct, de, ls, fs, fvld};
            e.xy    = {12'(h), 12'(v)};
            e.fxy   = {12'(fh), 12'(fv)};
            e.fc    = mFrames;
            expQ.push_back(e);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (reset_n && expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("sb_flags", {vid.hsync, vid.vsync, vid.de, vid.line_start, vid.frame_start, vid.fetch_valid}, e.flags);
            checkOutput("sb_xy", {vid.x, vid.y}, e.xy);
            checkOutput("sb_fetch_xy", {vid.fetch_x, vid.fetch_y}, e.fxy);
            checkOutput("sb_rgb", vid.rgb, e.rgb);
            checkOutput("sb_frame_count", vid.frame_count, e.fc);
         end
      end
   end

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_flags"}, {vid.hsync, vid.vsync, vid.de, vid.line_start, vid.frame_start, vid.fetch_valid}, 6'b110000);
      checkOutput({tag, "_xy"}, {vid.x, vid.y}, {12'd0, 12'(VA)});
      checkOutput({tag, "_fetch_xy"}, {vid.fetch_x, vid.fetch_y}, {12'(PF), 12'(VA)});
      checkOutput({tag, "_rgb"}, vid.rgb, 24'h0);
      checkOutput({tag, "_frame_count"}, vid.frame_count, 16'd0);
   endtask

   task automatic measureLead(input logic [1:0] pat, input logic [15:0] expFrames);
      int cnt;
      applyStimulus(1'b1, pat);
      cnt = 0;
      do begin
         @(negedge clock);
         cnt++;
      end while (!vid.de && cnt < 4 * FRAME);
      checkOutput("first_de_lead", cnt, LEAD);
      checkOutput("first_de_xy", {vid.x, vid.y}, 24'd0);
      checkOutput("first_de_frame_start", vid.frame_start, 1'b1);
      checkOutput("first_de_frame_count", vid.frame_count, expFrames);
   endtask

   task automatic waitPos(input int wx, input int wy, input bit onFetch, input string tag);
      int cnt;
      cnt = 0;
      while (cnt < 2 * FRAME) begin
         if (onFetch ? (vid.fetch_valid && vid.fetch_x == 12'(wx) && vid.fetch_y == 12'(wy))
                     : (vid.x == 12'(wx) && vid.y == 12'(wy)))
            break;
         @(negedge clock);
         cnt++;
      end
      if (cnt >= 2 * FRAME) checkOutput({tag, "_timeout"}, 1'b0, 1'b1);
   endtask

   int deCount, hsCount, vsCount;
   logic [23:0] rgbAt7, rgbAt8, rgbAt63, rgbAt64;
   logic [15:0] heldFrames;

   initial begin
      repeat (3) @(negedge clock);
      checkResetValues("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      measureLead(2'd1, 16'd1);

      // One full frame starting at its frame_start, with a mid-frame pattern change.
      deCount = 0; hsCount = 0; vsCount = 0;
      for (int i = 0; i < FRAME; i++) begin
         deCount += int'(vid.de);
         hsCount += int'(!vid.hsync);
         vsCount += int'(!vid.vsync);
         if (vid.y == 12'd0 && vid.x == 12'd7)  rgbAt7  = vid.rgb;
         if (vid.y == 12'd0 && vid.x == 12'd8)  rgbAt8  = vid.rgb;
         if (vid.y == 12'd0 && vid.x == 12'd63) rgbAt63 = vid.rgb;
         if (vid.y == 12'd0 && vid.x == 12'd64) rgbAt64 = vid.rgb;
         if (i == 500) applyStimulus(1'b1, 2'd2);
         @(negedge clock);
      end
      checkOutput("frame_de_cycles", deCount, HA * VA);
      checkOutput("frame_hsync_low", hsCount, HS * VT);
      checkOutput("frame_vsync_low", vsCount, VS * HT);
      checkOutput("frame_period", vid.frame_start, 1'b1);
      checkOutput("frame_count_2", vid.frame_count, 16'd2);
      checkOutput("bar_x7", rgbAt7, 24'hFFFFFF);
      checkOutput("bar_x8", rgbAt8, 24'hFFFF00);
      checkOutput("bar_x63", rgbAt63, 24'h000000);
      checkOutput("bar_blank", rgbAt64, 24'h000000);

      repeat (32) @(negedge clock);
      checkOutput("checker_xy", {vid.x, vid.y}, {12'd32, 12'd0});
      checkOutput("checker_rgb", vid.rgb, 24'hFFFFFF);

      waitPos(HA - 2, 5, 1'b1, "fetch_line");
      repeat (2) @(negedge clock);
      checkOutput("fetch_line_lead", {vid.de, vid.x, vid.y}, {1'b1, 12'(HA - 2), 12'd5});
      waitPos(0, 6, 1'b1, "fetch_next_line");
      checkOutput("fetch_next_line_pos", {vid.x, vid.y}, {12'(HT - 2), 12'd5});
      repeat (2) @(negedge clock);
      checkOutput("fetch_next_line_lead", {vid.de, vid.x, vid.y}, {1'b1, 12'd0, 12'd6});
      waitPos(0, 0, 1'b1, "fetch_wrap");
      checkOutput("fetch_wrap_pos", {vid.x, vid.y}, {12'(HT - 2), 12'(VT - 1)});
      repeat (2) @(negedge clock);
      checkOutput("fetch_wrap_frame_start", {vid.de, vid.frame_start}, 2'b11);

      waitPos(30, 10, 1'b0, "drop_pos");
      heldFrames = vid.frame_count;
      applyStimulus(1'b0, 2'd3);
      @(negedge clock);
      checkOutput("drop_flags", {vid.de, vid.hsync, vid.vsync}, 3'b011);
      checkOutput("drop_xy", {vid.x, vid.y}, {12'd0, 12'(VA)});
      repeat (5) @(negedge clock);
      checkOutput("drop_frame_count_held", vid.frame_count, heldFrames);
      measureLead(2'd3, heldFrames + 16'd1);

      waitPos(20, 3, 1'b0, "async_pos");
      #2;
      reset_n = 1'b0;
      #1;
      checkResetValues("async_reset");
      applyStimulus(1'b0, 2'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
